// File: rtl/sb_cfg_pkg.sv
//------------------------------------------------------------------------------
// Module   : sb_cfg_pkg
// Purpose  : Shared types and helpers for the switch-box configuration loader.
//            - sb_state_t         : loader sequencing states
//            - SB_BITS_PER_TRACK  : config bits per switch-box track element
//            - nbeats(w, cw)      : words needed to carry one w-track frame
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package sb_cfg_pkg;

  localparam int SB_BITS_PER_TRACK = 6;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_COMMIT = 2'd2
  } sb_state_t;

  // Ceiling division of the frame size by the word width.
  function automatic int nbeats(input int w, input int cw);
    return (w * SB_BITS_PER_TRACK + cw - 1) / cw;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sb_cfg_shadow.sv
//------------------------------------------------------------------------------
// Module   : sb_cfg_shadow
// Purpose  : Shadow register that assembles one configuration frame from
//            CW-bit words. Beat k lands in bits [k*CW +: CW], LSB-first; the
//            final beat only stores the bits that fit inside the frame.
// Ports    : clk       - clock
//            rst_n     - synchronous active-low reset (clears the shadow)
//            i_wr_en   - write the current word
//            i_beat    - beat index selecting the destination slice
//            i_data    - config word
//            o_shadow  - assembled frame
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module sb_cfg_shadow #(
  parameter int NBITS  = 48,
  parameter int CW     = 8,
  parameter int NBEATS = 6,
  parameter int CNTW   = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_wr_en,
  input  logic [CNTW-1:0]  i_beat,
  input  logic [CW-1:0]    i_data,
  output logic [NBITS-1:0] o_shadow
);

  logic [NBITS-1:0] w_shadow;

  // One register per beat; the last one is narrowed to the bits remaining in
  // the frame, which is what discards the unused upper bits of the last word.
  for (genvar k = 0; k < NBEATS; k++) begin : g_beat
    localparam int LO  = k * CW;
    localparam int WID = (k == NBEATS - 1) ? (NBITS - LO) : CW;

    logic [WID-1:0] r_word;

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        r_word <= '0;
      end else if (i_wr_en && (i_beat == CNTW'(k))) begin
        r_word <= i_data[WID-1:0];
      end
    end

    assign w_shadow[LO +: WID] = r_word;
  end

  assign o_shadow = w_shadow;

endmodule

`default_nettype wire

// File: rtl/switch_box_config_loader.sv
//------------------------------------------------------------------------------
// Module   : switch_box_config_loader
// Purpose  : Loads a W-track switch-box configuration frame (W*6 bits) as a
//            stream of CW-bit words and commits it atomically to the switch
//            box control bus, so the fabric never sees a partial frame.
// Ports    : clk        - clock
//            rst_n      - synchronous active-low reset
//            cfg_start  - opens a new frame (honoured only when idle)
//            cfg_abort  - discards the frame being loaded
//            cfg_data   - config word
//            cfg_valid  - cfg_data valid
//            cfg_ready  - loader accepts a word this cycle
//            cfg_parity - even parity of cfg_data (CFG_PARITY_EN only)
//            c          - committed control bus, track i on [i*6+5:i*6]
//            busy       - frame in progress (LOAD or COMMIT)
//            done       - one-cycle pulse when a frame completes
//            err        - sticky parity error for the current frame
// Options  : `define CFG_PARITY_EN enables per-word parity checking; a frame
//            with any parity error completes but does not update c.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module switch_box_config_loader
  import sb_cfg_pkg::*;
#(
  parameter int W  = 8,
  parameter int CW = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          cfg_start,
  input  logic                          cfg_abort,
  input  logic [CW-1:0]                 cfg_data,
  input  logic                          cfg_valid,
  output logic                          cfg_ready,
`ifdef CFG_PARITY_EN
  input  logic                          cfg_parity,
`endif
  output logic [W*SB_BITS_PER_TRACK-1:0] c,
  output logic                          busy,
  output logic                          done,
  output logic                          err
);

  localparam int NBITS  = W * SB_BITS_PER_TRACK;
  localparam int NBEATS = nbeats(W, CW);
  localparam int CNTW   = $clog2(NBEATS + 1);

  sb_state_t         r_state;
  sb_state_t         w_next;
  logic [CNTW-1:0]   r_cnt;
  logic [NBITS-1:0]  r_c;
  logic              r_done;
  logic [NBITS-1:0]  w_shadow;
  logic              w_ready;
  logic              w_accept;
  logic              w_last;
  logic              w_start;
  logic              w_err;

  assign w_start  = (r_state == ST_IDLE) && cfg_start;
  assign w_accept = w_ready && cfg_valid;
  assign w_last   = (r_cnt == CNTW'(NBEATS - 1));

  //--------------------------------------------------------------------------
  // FSM
  //--------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next  = r_state;
    w_ready = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (cfg_start) begin
          w_next = ST_LOAD;
        end
      end
      ST_LOAD: begin
        w_ready = 1'b1;
        // Abort takes priority even over an accepted final beat.
        if (cfg_abort) begin
          w_next = ST_IDLE;
        end else if (cfg_valid && w_last) begin
          w_next = ST_COMMIT;
        end
      end
      ST_COMMIT: begin
        w_next = ST_IDLE;
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  //--------------------------------------------------------------------------
  // Beat counter: reaches NBEATS on the final beat and is reloaded on the
  // next start, so it never wraps within a frame.
  //--------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (w_start) begin
      r_cnt <= '0;
    end else if (w_accept) begin
      r_cnt <= r_cnt + CNTW'(1);
    end
  end

  sb_cfg_shadow #(
    .NBITS  (NBITS),
    .CW     (CW),
    .NBEATS (NBEATS),
    .CNTW   (CNTW)
  ) u_shadow (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_wr_en  (w_accept),
    .i_beat   (r_cnt),
    .i_data   (cfg_data),
    .o_shadow (w_shadow)
  );

  //--------------------------------------------------------------------------
  // Parity tracking
  //--------------------------------------------------------------------------
`ifdef CFG_PARITY_EN
  logic r_err;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_err <= 1'b0;
    end else if (w_start) begin
      r_err <= 1'b0;
    end else if (w_accept && ((^cfg_data) != cfg_parity)) begin
      r_err <= 1'b1;
    end
  end

  assign w_err = r_err;
`else
  assign w_err = 1'b0;
`endif

  //--------------------------------------------------------------------------
  // Commit: c and done update together one cycle after the final beat.
  //--------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_c    <= '0;
      r_done <= 1'b0;
    end else begin
      r_done <= (r_state == ST_COMMIT);
      if ((r_state == ST_COMMIT) && !w_err) begin
        r_c <= w_shadow;
      end
    end
  end

  assign c         = r_c;
  assign done      = r_done;
  assign busy      = (r_state != ST_IDLE);
  assign cfg_ready = w_ready;
  assign err       = w_err;

endmodule

`default_nettype wire

// File: tb/tb_switch_box_config_loader.sv
//------------------------------------------------------------------------------
// Module   : tb_switch_box_config_loader
// Purpose  : Directed self-checking bench for switch_box_config_loader, with
//            an 8-track instance and a 3-track instance (partial last word).
//            Parity scenarios are included when CFG_PARITY_EN is defined.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_switch_box_config_loader;

  logic        clk;
  logic        rst_n;
  logic        cfg_start;
  logic        cfg_abort;
  logic [7:0]  cfg_data;
  logic        cfg_valid;
  logic        cfg_parity;
  logic        cfg_ready;
  logic [47:0] c;
  logic        busy;
  logic        done;
  logic        err;

  logic        cfg_start3;
  logic        cfg_valid3;
  logic        cfg_ready3;
  logic [17:0] c3;
  logic        busy3;
  logic        done3;
  logic        err3;

  int checks;
  int failures;

  switch_box_config_loader #(.W(8), .CW(8)) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cfg_start  (cfg_start),
    .cfg_abort  (cfg_abort),
    .cfg_data   (cfg_data),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
`ifdef CFG_PARITY_EN
    .cfg_parity (cfg_parity),
`endif
    .c          (c),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  switch_box_config_loader #(.W(3), .CW(8)) u_dut3 (
    .clk        (clk),
    .rst_n      (rst_n),
    .cfg_start  (cfg_start3),
    .cfg_abort  (1'b0),
    .cfg_data   (cfg_data),
    .cfg_valid  (cfg_valid3),
    .cfg_ready  (cfg_ready3),
`ifdef CFG_PARITY_EN
    .cfg_parity (cfg_parity),
`endif
    .c          (c3),
    .busy       (busy3),
    .done       (done3),
    .err        (err3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_word(input logic [7:0] d);
    cfg_data   = d;
    cfg_parity = ^d;
    cfg_valid  = 1'b1;
    step();
    cfg_valid  = 1'b0;
  endtask

  task automatic start_frame();
    cfg_start = 1'b1;
    step();
    cfg_start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    cfg_valid = 1'b1;
    cfg_data  = 8'h5A;
    step();
    step();
    checks++; if (c !== 48'h0)   begin failures++; $display("FAIL reset_c got=%h exp=%h", c, 48'h0); end
    checks++; if (cfg_ready !== 1'b0) begin failures++; $display("FAIL reset_ready got=%b exp=0", cfg_ready); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (err !== 1'b0)  begin failures++; $display("FAIL reset_err got=%b exp=0", err); end
    checks++; if (c3 !== 18'h0)  begin failures++; $display("FAIL reset_c3 got=%h exp=0", c3); end
    cfg_valid = 1'b0;
    rst_n     = 1'b1;
    step();
  endtask

  task automatic test_full_frame();
    start_frame();
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL full_busy_load got=%b exp=1", busy); end
    checks++; if (cfg_ready !== 1'b1) begin failures++; $display("FAIL full_ready_load got=%b exp=1", cfg_ready); end
    for (int k = 0; k < 6; k++) load_word(8'(k + 1));
    checks++; if (cfg_ready !== 1'b0) begin failures++; $display("FAIL full_ready_commit got=%b exp=0", cfg_ready); end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL full_busy_commit got=%b exp=1", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL full_done_early got=%b exp=0", done); end
    checks++; if (c !== 48'h0) begin failures++; $display("FAIL full_c_early got=%h exp=%h", c, 48'h0); end
    step();
    checks++; if (c !== 48'h060504030201) begin failures++; $display("FAIL full_c got=%h exp=%h", c, 48'h060504030201); end
    checks++; if (done !== 1'b1) begin failures++; $display("FAIL full_done got=%b exp=1", done); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL full_busy_idle got=%b exp=0", busy); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL full_err got=%b exp=0", err); end
    step();
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL full_done_pulse got=%b exp=0", done); end
    checks++; if (c !== 48'h060504030201) begin failures++; $display("FAIL full_c_hold got=%h exp=%h", c, 48'h060504030201); end
  endtask

  task automatic test_back_to_back();
    start_frame();
    for (int k = 0; k < 6; k++) load_word(8'(8'hA0 + k));
    step();
    checks++; if (c !== 48'hA5A4A3A2A1A0) begin failures++; $display("FAIL b2b_c1 got=%h exp=%h", c, 48'hA5A4A3A2A1A0); end
    checks++; if (done !== 1'b1) begin failures++; $display("FAIL b2b_done1 got=%b exp=1", done); end
    // Next frame opens in the same cycle as the done pulse.
    start_frame();
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL b2b_restart got=%b exp=1", busy); end
    for (int k = 0; k < 6; k++) load_word(8'(8'hB0 + k));
    step();
    checks++; if (c !== 48'hB5B4B3B2B1B0) begin failures++; $display("FAIL b2b_c2 got=%h exp=%h", c, 48'hB5B4B3B2B1B0); end
    checks++; if (done !== 1'b1) begin failures++; $display("FAIL b2b_done2 got=%b exp=1", done); end
    step();
  endtask

  task automatic test_stall();
    start_frame();
    for (int k = 0; k < 3; k++) load_word(8'(k + 1));
    for (int s = 0; s < 3; s++) begin
      // A start pulse mid-frame must not restart the load.
      cfg_start = (s == 0);
      step();
      cfg_start = 1'b0;
      checks++; if (busy !== 1'b1) begin failures++; $display("FAIL stall_busy cyc=%0d got=%b exp=1", s, busy); end
      checks++; if (done !== 1'b0) begin failures++; $display("FAIL stall_done cyc=%0d got=%b exp=0", s, done); end
    end
    for (int k = 3; k < 6; k++) load_word(8'(k + 1));
    step();
    checks++; if (c !== 48'h060504030201) begin failures++; $display("FAIL stall_c got=%h exp=%h", c, 48'h060504030201); end
    checks++; if (done !== 1'b1) begin failures++; $display("FAIL stall_done got=%b exp=1", done); end
    step();
  endtask

  task automatic test_abort();
    start_frame();
    for (int k = 0; k < 3; k++) load_word(8'h77);
    cfg_abort = 1'b1;
    step();
    cfg_abort = 1'b0;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL abort_busy got=%b exp=0", busy); end
    checks++; if (cfg_ready !== 1'b0) begin failures++; $display("FAIL abort_ready got=%b exp=0", cfg_ready); end
    for (int s = 0; s < 2; s++) begin
      step();
      checks++; if (done !== 1'b0) begin failures++; $display("FAIL abort_done cyc=%0d got=%b exp=0", s, done); end
      checks++; if (c !== 48'h060504030201) begin failures++; $display("FAIL abort_c cyc=%0d got=%h exp=%h", s, c, 48'h060504030201); end
    end

    // Abort coinciding with the accepted final beat suppresses the commit.
    start_frame();
    for (int k = 0; k < 5; k++) load_word(8'hEE);
    cfg_data  = 8'hEE;
    cfg_valid = 1'b1;
    cfg_abort = 1'b1;
    step();
    cfg_valid = 1'b0;
    cfg_abort = 1'b0;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL abort_last_busy got=%b exp=0", busy); end
    step();
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL abort_last_done got=%b exp=0", done); end
    checks++; if (c !== 48'h060504030201) begin failures++; $display("FAIL abort_last_c got=%h exp=%h", c, 48'h060504030201); end

    // Start and abort together in IDLE: start wins.
    cfg_start = 1'b1;
    cfg_abort = 1'b1;
    step();
    cfg_start = 1'b0;
    cfg_abort = 1'b0;
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL start_vs_abort got=%b exp=1", busy); end
    cfg_abort = 1'b1;
    step();
    cfg_abort = 1'b0;
    step();
  endtask

  task automatic test_partial_last();
    cfg_start3 = 1'b1;
    step();
    cfg_start3 = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cfg_data = 8'hFF; cfg_parity = 1'b0; cfg_valid3 = 1'b1;
      step();
    end
    cfg_valid3 = 1'b0;
    checks++; if (busy3 !== 1'b1) begin failures++; $display("FAIL part_busy_commit got=%b exp=1", busy3); end
    step();
    checks++; if (c3 !== 18'h3FFFF) begin failures++; $display("FAIL part_c_ff got=%h exp=%h", c3, 18'h3FFFF); end
    checks++; if (done3 !== 1'b1) begin failures++; $display("FAIL part_done got=%b exp=1", done3); end
    step();
    // 12, 34, FD: only the low 2 bits (01) of the last word are kept.
    cfg_start3 = 1'b1;
    step();
    cfg_start3 = 1'b0;
    cfg_data = 8'h12; cfg_parity = ^cfg_data; cfg_valid3 = 1'b1; step();
    cfg_data = 8'h34; cfg_parity = ^cfg_data; step();
    cfg_data = 8'hFD; cfg_parity = ^cfg_data; step();
    cfg_valid3 = 1'b0;
    step();
    checks++; if (c3 !== 18'h13412) begin failures++; $display("FAIL part_c_mix got=%h exp=%h", c3, 18'h13412); end
    step();
  endtask

`ifdef CFG_PARITY_EN
  task automatic test_parity();
    start_frame();
    load_word(8'h11);
    load_word(8'h22);
    cfg_data   = 8'h07;
    cfg_parity = 1'b0;
    cfg_valid  = 1'b1;
    step();
    cfg_valid  = 1'b0;
    checks++; if (err !== 1'b1) begin failures++; $display("FAIL par_err_set got=%b exp=1", err); end
    load_word(8'h44);
    load_word(8'h55);
    load_word(8'h66);
    step();
    checks++; if (done !== 1'b1) begin failures++; $display("FAIL par_done got=%b exp=1", done); end
    checks++; if (err !== 1'b1) begin failures++; $display("FAIL par_err got=%b exp=1", err); end
    checks++; if (c !== 48'h060504030201) begin failures++; $display("FAIL par_c got=%h exp=%h", c, 48'h060504030201); end
    step();
    checks++; if (err !== 1'b1) begin failures++; $display("FAIL par_err_sticky got=%b exp=1", err); end
    start_frame();
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL par_err_clear got=%b exp=0", err); end
    cfg_abort = 1'b1;
    step();
    cfg_abort = 1'b0;
    step();
  endtask
`endif

  initial begin
    checks     = 0;
    failures   = 0;
    rst_n      = 1'b0;
    cfg_start  = 1'b0;
    cfg_abort  = 1'b0;
    cfg_data   = 8'h00;
    cfg_valid  = 1'b0;
    cfg_parity = 1'b0;
    cfg_start3 = 1'b0;
    cfg_valid3 = 1'b0;

    test_reset();
    test_full_frame();
    test_back_to_back();
    test_stall();
    test_abort();
    test_partial_last();
`ifdef CFG_PARITY_EN
    test_parity();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
